// File: rtl/mp_add_seq_if.sv
// Operand/result handshake bundle for mp_add_seq; in_sub exists only when MPADD_SUB_EN is defined.
interface mp_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int N = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
`ifdef MPADD_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
`ifdef MPADD_SUB_EN
        input  in_sub,
`endif
        output in_ready, out_valid, out_sum, out_cout, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
`ifdef MPADD_SUB_EN
        output in_sub,
`endif
        input  in_ready, out_valid, out_sum, out_cout, out_zero
    );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision A+B+cin, one 16-bit word per cycle through a shared carry-skip adder, LSW first.
// Optional subtract mode (A-B) is enabled by defining MPADD_SUB_EN.
module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    mp_add_seq_if.slave  bus
);
    localparam int N  = 16 * WORDS;
    localparam int CW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_reg;
    logic [CW-1:0]  cnt_reg;
    logic           carry_reg;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   acc_reg;
    logic           out_valid_reg;
    logic [N-1:0]   out_sum_reg;
    logic           out_cout_reg;
    logic           out_zero_reg;

    logic [15:0]    csa_sum;
    logic           csa_cout;
    logic [N-1:0]   acc_next;
    logic [WORDS-1:0] word_zero;
    logic           last_word;
    logic           sub_sel;

`ifdef MPADD_SUB_EN
    assign sub_sel = bus.in_sub;
`else
    assign sub_sel = 1'b0;
`endif

    // 16-bit carry-skip adder: four 4-bit ripple blocks, each bypassed when all bits propagate.
    always_comb begin
        logic c;
        logic blk_cin;
        logic rc;
        logic p;
        logic p_all;
        csa_sum = '0;
        c       = carry_reg;
        for (int blk = 0; blk < 4; blk++) begin
            blk_cin = c;
            rc      = c;
            p_all   = 1'b1;
            for (int j = 0; j < 4; j++) begin
                p                   = a_reg[4*blk+j] ^ b_reg[4*blk+j];
                csa_sum[4*blk+j]    = p ^ rc;
                rc                  = (a_reg[4*blk+j] & b_reg[4*blk+j]) | (p & rc);
                p_all               = p_all & p;
            end
            c = p_all ? blk_cin : rc;
        end
        csa_cout = c;
    end

    // Result words enter at the top and move down, so word k lands in place after the last shift.
    assign acc_next  = {csa_sum, acc_reg[N-1:16]};
    assign last_word = (cnt_reg == CW'(WORDS - 1));

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_zero
        assign word_zero[gi] = ~|acc_next[16*gi +: 16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_cout_reg  <= 1'b0;
            out_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.in_a;
                        b_reg     <= sub_sel ? ~bus.in_b : bus.in_b;
                        carry_reg <= sub_sel ? 1'b1 : bus.in_cin;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= {16'h0000, a_reg[N-1:16]};
                    b_reg     <= {16'h0000, b_reg[N-1:16]};
                    acc_reg   <= acc_next;
                    carry_reg <= csa_cout;
                    if (last_word) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        out_sum_reg   <= acc_next;
                        out_cout_reg  <= csa_cout;
                        out_zero_reg  <= &word_zero;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = out_sum_reg;
    assign bus.out_cout  = out_cout_reg;
    assign bus.out_zero  = out_zero_reg;
endmodule
